// File: rtl/dmem_sized.sv
// Parametrised byte-addressed data memory with sized, byte-lane stores,
// sign/zero-extending registered loads, misalignment detection and an
// optional post-reset hardware clear guarded by a ready handshake.
module dmem_sized #(
    parameter int ADDR_W         = 12,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              DM_W,
    input  logic              DM_R,
    input  logic [1:0]        DM_size,
    input  logic              DM_signed,
    input  logic [ADDR_W-1:0] DM_addr,
    input  logic [31:0]       DM_wdata,
    output logic [31:0]       DM_rdata,
    output logic              DM_rvalid,
    output logic              DM_misalign,
    output logic              DM_ready
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic {
        S_CLEAR,
        S_RUN
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
    localparam logic [IDX_W-1:0] LAST_IDX = '1;

    logic [31:0] mem [DEPTH];

    state_t           state, state_nx;
    logic [IDX_W-1:0] clr_cnt, clr_cnt_nx;
    logic             clr_we;

    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             req;
    logic             bad;
    logic             rd_go;
    logic             wr_go;
    logic [3:0]       be;
    logic [31:0]      wdata_lanes;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      load_val;

    // State, clear counter and registered ready flag.
    // Ready is registered off the next state so it is low throughout reset
    // even when the clear is skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RST_STATE;
            clr_cnt  <= '0;
            DM_ready <= 1'b0;
        end else begin
            state    <= state_nx;
            clr_cnt  <= clr_cnt_nx;
            DM_ready <= (state_nx == S_RUN);
        end
    end

    // Next-state logic: walk the array once, then run.
    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        clr_we     = 1'b0;
        case (state)
            S_CLEAR: begin
                clr_we     = 1'b1;
                clr_cnt_nx = clr_cnt + 1'b1;
                if (clr_cnt == LAST_IDX) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                state_nx = S_RUN;
            end
            default: begin
                state_nx = RST_STATE;
            end
        endcase
    end

    // Request decode, lane enables, store data replication and load extraction.
    always_comb begin
        idx  = DM_addr[ADDR_W-1:2];
        lane = DM_addr[1:0];
        req  = DM_ready & ena & (DM_W | DM_R);

        bad         = 1'b0;
        be          = '0;
        wdata_lanes = DM_wdata;
        rd_word     = mem[idx];
        rd_byte     = rd_word[{lane, 3'b000} +: 8];
        rd_half     = lane[1] ? rd_word[31:16] : rd_word[15:0];
        load_val    = rd_word;

        case (DM_size)
            2'b00: begin
                be          = 4'b0001 << lane;
                wdata_lanes = {4{DM_wdata[7:0]}};
                load_val    = {{24{DM_signed & rd_byte[7]}}, rd_byte};
            end
            2'b01: begin
                bad         = lane[0];
                be          = lane[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{DM_wdata[15:0]}};
                load_val    = {{16{DM_signed & rd_half[15]}}, rd_half};
            end
            2'b10: begin
                bad         = (lane != 2'b00);
                be          = 4'b1111;
                wdata_lanes = DM_wdata;
                load_val    = rd_word;
            end
            default: begin
                bad = 1'b1;
            end
        endcase

        rd_go = req & ~bad & DM_R;
        wr_go = req & ~bad & DM_W;
    end

    // Array write port: clear sweep takes priority, otherwise lane-masked store.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (wr_go) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
                end
            end
        end
    end

    // Registered load result and one-cycle status strobes.
    // Load data is taken from the pre-store word, giving read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DM_rdata    <= '0;
            DM_rvalid   <= 1'b0;
            DM_misalign <= 1'b0;
        end else begin
            DM_rvalid   <= rd_go;
            DM_misalign <= req & bad;
            if (rd_go) begin
                DM_rdata <= load_val;
            end
        end
    end

endmodule

// File: tb/tb_dmem_sized.sv
// Directed self-checking bench for dmem_sized (ADDR_W=6, 16-word array).
module tb_dmem_sized;

    localparam int AW    = 6;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic          DM_W;
    logic          DM_R;
    logic [1:0]    DM_size;
    logic          DM_signed;
    logic [AW-1:0] DM_addr;
    logic [31:0]   DM_wdata;
    logic [31:0]   DM_rdata;
    logic          DM_rvalid;
    logic          DM_misalign;
    logic          DM_ready;

    int errors = 0;
    int checks = 0;

    dmem_sized #(
        .ADDR_W(AW),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ena(ena),
        .DM_W(DM_W),
        .DM_R(DM_R),
        .DM_size(DM_size),
        .DM_signed(DM_signed),
        .DM_addr(DM_addr),
        .DM_wdata(DM_wdata),
        .DM_rdata(DM_rdata),
        .DM_rvalid(DM_rvalid),
        .DM_misalign(DM_misalign),
        .DM_ready(DM_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          ena;
        logic          w;
        logic          r;
        logic [1:0]    size;
        logic          sgn;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   exp_rdata;
        logic          exp_rvalid;
        logic          exp_mis;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e, input logic w, input logic r, input logic [1:0] sz,
                         input logic sg, input logic [AW-1:0] a, input logic [31:0] wd);
        ena       = e;
        DM_W      = w;
        DM_R      = r;
        DM_size   = sz;
        DM_signed = sg;
        DM_addr   = a;
        DM_wdata  = wd;
    endtask

    // Waits for DM_ready with a cycle budget while hammering loads that must be ignored.
    task automatic wait_ready(input string name);
        int  cnt;
        logic spurious;
        cnt      = 0;
        spurious = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 6'h00, 32'h0);
        while (!DM_ready && cnt < 40) begin
            step();
            cnt++;
            if (DM_rvalid || DM_misalign) spurious = 1'b1;
        end
        chk({name, " cycles to ready"}, cnt, DEPTH);
        chk({name, " no strobes during clear"}, {31'b0, spurious}, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 6'h00, 32'h0);
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 6'h00, 32'h0);
        #3;
        chk("reset rdata", DM_rdata, 32'h0);
        chk("reset rvalid", {31'b0, DM_rvalid}, 32'h0);
        chk("reset misalign", {31'b0, DM_misalign}, 32'h0);
        chk("reset ready", {31'b0, DM_ready}, 32'h0);
        step();
        step();
        rst_n = 1'b1;

        wait_ready("clear1");

        // Back-to-back loads of every word: all zero after the clear.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, AW'(i * 4), 32'h0);
            step();
            chk($sformatf("cleared word %0d rdata", i), DM_rdata, 32'h0);
            chk($sformatf("cleared word %0d rvalid", i), {31'b0, DM_rvalid}, 32'h1);
        end

        //                 ena   w     r     size   sgn   addr   wdata          rdata          rv    mis
        vecs.push_back(vec_t'{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 6'h10, 32'h8899AABB, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 6'h13, 32'h0,        32'hFFFFFF88, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 6'h13, 32'h0,        32'h00000088, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b1, 2'b01, 1'b1, 6'h10, 32'h0,        32'hFFFFAABB, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 6'h12, 32'h0,        32'h00008899, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 6'h10, 32'h0,        32'hFFFFFFBB, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 6'h20, 32'h11223344, 32'hFFFFFFBB, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 6'h21, 32'hFFFFFF5A, 32'hFFFFFFBB, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 6'h20, 32'h0,        32'h11225A44, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 6'h22, 32'h1234BEEF, 32'h11225A44, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 6'h20, 32'h0,        32'hBEEF5A44, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 6'h06, 32'hDEADBEEF, 32'hBEEF5A44, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 6'h03, 32'h0,        32'hBEEF5A44, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 6'h00, 32'h0,        32'hBEEF5A44, 1'b0, 1'b1});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 6'h04, 32'h0,        32'h00000000, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 6'h00, 32'h0,        32'h00000000, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 6'h30, 32'h00000001, 32'h00000000, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 6'h30, 32'h00000002, 32'h00000001, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 6'h30, 32'h0,        32'h00000002, 1'b1, 1'b0});
        vecs.push_back(vec_t'{1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 6'h30, 32'h0,        32'h00000002, 1'b0, 1'b0});
        vecs.push_back(vec_t'{1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 6'h12, 32'h0,        32'h00000099, 1'b1, 1'b0});

        foreach (vecs[i]) begin
            drive(vecs[i].ena, vecs[i].w, vecs[i].r, vecs[i].size, vecs[i].sgn,
                  vecs[i].addr, vecs[i].wdata);
            step();
            chk($sformatf("vec %0d rdata", i), DM_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec %0d rvalid", i), {31'b0, DM_rvalid}, {31'b0, vecs[i].exp_rvalid});
            chk($sformatf("vec %0d misalign", i), {31'b0, DM_misalign}, {31'b0, vecs[i].exp_mis});
        end
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 6'h00, 32'h0);
        step();
        chk("idle holds rdata", DM_rdata, 32'h00000099);

        // Asynchronous reset clears outputs without a clock edge.
        rst_n = 1'b0;
        #2;
        chk("async reset rdata", DM_rdata, 32'h0);
        chk("async reset ready", {31'b0, DM_ready}, 32'h0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("mid-clear ready low", {31'b0, DM_ready}, 32'h0);

        // Reset again in the middle of the clear: the sweep restarts from word 0.
        rst_n = 1'b0;
        #2;
        chk("mid-clear reset rdata", DM_rdata, 32'h0);
        step();
        rst_n = 1'b1;
        wait_ready("clear2");

        drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 6'h30, 32'h0);
        step();
        chk("recleared word 0x30", DM_rdata, 32'h0);
        chk("recleared rvalid", {31'b0, DM_rvalid}, 32'h1);
        drive(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 6'h10, 32'h0);
        step();
        chk("recleared word 0x10", DM_rdata, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 6'h00, 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
